// File: rtl/commit_pkg.sv
// Shared definitions for the in-order commit unit.
//   - MIPS opcode / funct / rt constants used to classify head-window entries
//   - cls_t: per-slot instruction class flags
//   - state_e: store / break handshake FSM encoding
//   - instr_class(): instruction word -> class flags
package commit_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FN_BREAK   = 6'h0D;
  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_BRK   = 2'd2
  } state_e;

  typedef struct packed {
    logic wr_reg;   // retires immediately and writes the regfile
    logic branch;   // needs its delay slot in the same commit group
    logic sw;       // slot-0 only, goes through the store handshake
    logic brk;      // slot-0 only, goes through the break handshake
  } cls_t;

  // Anything that is not a branch, store or break is treated as a
  // zero-latency register-writing op (ALU, lui, shifts, jal, lw, mult, mfhi).
  function automatic cls_t instr_class(input logic [31:0] instr);
    cls_t c;
    logic [5:0] op;
    op       = instr[31:26];
    c.brk    = (op == OP_SPECIAL) && (instr[5:0] == FN_BREAK);
    c.sw     = (op == OP_SW);
    c.branch = (op == OP_BEQ) || (op == OP_BNE) ||
               ((op == OP_REGIMM) &&
                ((instr[20:16] == RT_BLTZ) || (instr[20:16] == RT_BGEZ)));
    c.wr_reg = !(c.brk || c.sw || c.branch);
    return c;
  endfunction

endpackage

// File: rtl/commit_multi_if.sv
// Head-window / commit-result bundle of the commit unit.
//   master : ROB head window + memory/break handshake side (drives head_*,
//            regstat_tag, memio_bit, mem_grant, rls, stall)
//   slave  : commit unit (drives commit_mask, commit_cnt, regfile_we,
//            regstat_clr, rollback, stall_rollback, mem_req, write_cache,
//            memio_we, stat_output)
interface commit_multi_if #(
  parameter int COMMIT_W  = 2,
  parameter int ROB_IDX_W = 5,
  parameter int DATA_W    = 32
);
  logic [COMMIT_W-1:0][ROB_IDX_W-1:0] head_tag;
  logic [COMMIT_W-1:0]                head_ready;
  logic [COMMIT_W-1:0][DATA_W-1:0]    head_instr;
  logic [COMMIT_W-1:0][DATA_W-1:0]    head_value;
  logic [COMMIT_W-1:0][DATA_W-1:0]    pred_addr;
  logic [COMMIT_W-1:0][ROB_IDX_W-1:0] regstat_tag;
  logic                               memio_bit;
  logic                               mem_grant;
  logic                               rls;
  logic                               stall;

  logic [COMMIT_W-1:0]                commit_mask;
  logic [2:0]                         commit_cnt;
  logic [COMMIT_W-1:0]                regfile_we;
  logic [COMMIT_W-1:0]                regstat_clr;
  logic                               rollback;
  logic                               stall_rollback;
  logic                               mem_req;
  logic                               write_cache;
  logic                               memio_we;
  logic [7:0]                         stat_output;

  modport master (
    output head_tag, head_ready, head_instr, head_value, pred_addr,
           regstat_tag, memio_bit, mem_grant, rls, stall,
    input  commit_mask, commit_cnt, regfile_we, regstat_clr, rollback,
           stall_rollback, mem_req, write_cache, memio_we, stat_output
  );

  modport slave (
    input  head_tag, head_ready, head_instr, head_value, pred_addr,
           regstat_tag, memio_bit, mem_grant, rls, stall,
    output commit_mask, commit_cnt, regfile_we, regstat_clr, rollback,
           stall_rollback, mem_req, write_cache, memio_we, stat_output
  );
endinterface

// File: rtl/commit_decode.sv
// Per-slot instruction classifier.
//   instr : 32-bit instruction word of one head-window slot
//   cls   : class flags (wr_reg, branch, sw, brk)
module commit_decode
  import commit_pkg::*;
(
  input  logic [31:0] instr,
  output cls_t        cls
);
  assign cls = instr_class(instr);
endmodule

// File: rtl/commit_multi.sv
// In-order commit unit: retires up to COMMIT_W ROB head entries per clk.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : commit_multi_if.slave (head window in, commit results out)
//   retired_ctr / rollback_ctr : only when COMMIT_PERF_CTR_EN is defined
// Optional feature macro: COMMIT_PERF_CTR_EN (retire / rollback counters).
module commit_multi
  import commit_pkg::*;
#(
  parameter int COMMIT_W  = 2,
  parameter int ROB_IDX_W = 5,
  parameter int DATA_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  commit_multi_if.slave      bus
`ifdef COMMIT_PERF_CTR_EN
  ,
  output logic [31:0]        retired_ctr,
  output logic [15:0]        rollback_ctr
`endif
);

  if (COMMIT_W < 1 || COMMIT_W > 4) begin : g_w_chk
    $error("commit_multi: COMMIT_W must be in 1..4");
  end

  cls_t [COMMIT_W-1:0] cls;

  for (genvar i = 0; i < COMMIT_W; i++) begin : g_dec
    commit_decode u_dec (
      .instr (bus.head_instr[i][31:0]),
      .cls   (cls[i])
    );
  end

  state_e              state, state_n;
  logic                mem_req_n, write_cache_n, memio_we_n;
  logic [7:0]          stat_n;
  logic [COMMIT_W:0]   rdy_ext;
  logic [COMMIT_W-1:0] scan_mask, mask;
  logic                scan_rb, rb, stop, dly;
  logic [2:0]          cnt;

  // Extra always-0 slot: a branch in the last slot sees its delay slot
  // not ready and waits for the window to advance.
  assign rdy_ext = {1'b0, bus.head_ready};

  // IDLE-state retire scan, oldest first.
  always_comb begin
    scan_mask = '0;
    scan_rb   = 1'b0;
    stop      = 1'b0;
    dly       = 1'b0;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (dly) begin
        // delay slot rides along with its branch
        scan_mask[i] = 1'b1;
        dly          = 1'b0;
        if (scan_rb) stop = 1'b1;   // younger slots are wrong-path
      end else if (!stop) begin
        if (!bus.head_ready[i]) begin
          stop = 1'b1;
        end else if (cls[i].sw || cls[i].brk) begin
          // memio store retires alone; memory stores / breaks go via FSM
          if (i == 0 && cls[i].sw && bus.memio_bit) scan_mask[i] = 1'b1;
          stop = 1'b1;
        end else if (cls[i].branch) begin
          if (rdy_ext[i+1]) begin
            scan_mask[i] = 1'b1;
            dly          = 1'b1;
            scan_rb      = (bus.pred_addr[i] != bus.head_value[i]);
          end else begin
            stop = 1'b1;
          end
        end else begin
          scan_mask[i] = 1'b1;
        end
      end
    end
  end

  // FSM next state and final commit mask.
  always_comb begin
    state_n       = state;
    mem_req_n     = bus.mem_req;
    write_cache_n = 1'b0;
    memio_we_n    = 1'b0;
    stat_n        = bus.stat_output;
    mask          = '0;
    rb            = 1'b0;
    case (state)
      ST_IDLE: if (!bus.stall) begin
        mask = scan_mask;
        rb   = scan_rb;
        if (bus.head_ready[0] && cls[0].sw) begin
          if (bus.memio_bit) begin
            memio_we_n = 1'b1;
          end else begin
            state_n   = ST_STORE;
            mem_req_n = 1'b1;
          end
        end else if (bus.head_ready[0] && cls[0].brk) begin
          state_n = ST_BRK;
          stat_n  = bus.head_instr[0][13:6];
        end
      end
      // grant is honoured even under stall
      ST_STORE: if (bus.mem_grant) begin
        mask[0]       = 1'b1;
        write_cache_n = 1'b1;
        mem_req_n     = 1'b0;
        state_n       = ST_IDLE;
      end
      ST_BRK: if (bus.rls && !bus.stall) begin
        mask[0] = 1'b1;
        stat_n  = 8'h00;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    // head window is not trusted while reset is asserted
    if (rst) begin
      mask = '0;
      rb   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      bus.mem_req     <= 1'b0;
      bus.write_cache <= 1'b0;
      bus.memio_we    <= 1'b0;
      bus.stat_output <= 8'h00;
    end else begin
      state           <= state_n;
      bus.mem_req     <= mem_req_n;
      bus.write_cache <= write_cache_n;
      bus.memio_we    <= memio_we_n;
      bus.stat_output <= stat_n;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < COMMIT_W; i++) cnt = cnt + 3'(mask[i]);
  end

  always_comb begin
    for (int i = 0; i < COMMIT_W; i++) begin
      bus.regfile_we[i]  = mask[i] & cls[i].wr_reg;
      bus.regstat_clr[i] = mask[i] & (bus.regstat_tag[i] == bus.head_tag[i]);
    end
  end

  assign bus.commit_mask    = mask;
  assign bus.commit_cnt     = cnt;
  assign bus.rollback       = rb;
  assign bus.stall_rollback = !rst && (state == ST_IDLE) && bus.stall &&
                              bus.head_ready[0] && cls[0].branch &&
                              (bus.pred_addr[0] != bus.head_value[0]);

`ifdef COMMIT_PERF_CTR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_ctr  <= '0;
      rollback_ctr <= '0;
    end else begin
      retired_ctr  <= retired_ctr + 32'(cnt);
      rollback_ctr <= rollback_ctr + 16'(rb);
    end
  end
`endif

endmodule

// File: tb/tb_commit_multi.sv
// Self-checking bench for commit_multi (COMMIT_W=2): directed cases from the
// block description, then randomized windows checked against a behavioural
// model of the retire rules and handshakes.
module tb_commit_multi;
  localparam int W = 2, TW = 5, DW = 32;
  localparam int K_ALU = 0, K_BR = 1, K_SW = 2, K_BRK = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  commit_multi_if #(.COMMIT_W(W), .ROB_IDX_W(TW), .DATA_W(DW)) bus();

`ifdef COMMIT_PERF_CTR_EN
  logic [31:0] retired_ctr;
  logic [15:0] rollback_ctr;
`endif

  commit_multi #(.COMMIT_W(W), .ROB_IDX_W(TW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef COMMIT_PERF_CTR_EN
    ,
    .retired_ctr  (retired_ctr),
    .rollback_ctr (rollback_ctr)
`endif
  );

  int checks = 0, errors = 0;

  // model state: 0 idle, 1 waiting for store grant, 2 waiting for release
  int          m_state = 0;
  logic        m_mem_req = 0, m_wc = 0, m_mw = 0;
  logic [7:0]  m_stat = 8'h00;
  logic [31:0] m_ret = 0;
  logic [15:0] m_rbc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int klass(input logic [31:0] x);
    if (x[31:26] == 6'h2B) return K_SW;
    if (x[31:26] == 6'h00 && x[5:0] == 6'h0D) return K_BRK;
    if (x[31:26] == 6'h04 || x[31:26] == 6'h05) return K_BR;
    if (x[31:26] == 6'h01 && x[20:17] == 4'h0) return K_BR;
    return K_ALU;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2: return {6'h00, r[25:6], 6'h21};                 // addu
      3:       return {6'h0D, r[25:0]};                        // ori
      4:       return {6'h23, r[25:0]};                        // lw
      5:       return {(r[0] ? 6'h05 : 6'h04), r[25:0]};       // beq/bne
      6:       return {6'h01, r[25:21], 4'h0, r[16:0]};        // bltz/bgez
      7:       return {6'h2B, r[25:0]};                        // sw
      8:       return {6'h00, r[25:6], 6'h0D};                 // break
      default: return {6'h03, r[25:0]};                        // jal
    endcase
  endfunction

  task automatic idle_inputs();
    bus.head_tag = '0; bus.head_ready = '0; bus.head_instr = '0;
    bus.head_value = '0; bus.pred_addr = '0; bus.regstat_tag = '0;
    bus.memio_bit = 0; bus.mem_grant = 0; bus.rls = 0; bus.stall = 0;
  endtask

  task automatic rnd_inputs();
    for (int j = 0; j < W; j++) begin
      bus.head_ready[j]  = ($urandom_range(0, 3) != 0);
      bus.head_instr[j]  = rnd_instr();
      bus.head_value[j]  = $urandom;
      bus.pred_addr[j]   = $urandom_range(0, 1) ? bus.head_value[j] : $urandom;
      bus.head_tag[j]    = TW'($urandom_range(0, 3));
      bus.regstat_tag[j] = TW'($urandom_range(0, 3));
    end
    bus.memio_bit = $urandom_range(0, 1);
    bus.mem_grant = ($urandom_range(0, 2) == 0);
    bus.rls       = ($urandom_range(0, 3) == 0);
    bus.stall     = ($urandom_range(0, 4) == 0);
    rst           = ($urandom_range(0, 99) == 0);
  endtask

  // Called just after a rising edge with inputs already driven: checks the
  // combinational outputs against the model, advances the model across the
  // next edge and checks the registered outputs.
  task automatic run_cycle();
    logic [W-1:0] em, ewe, eclr;
    logic erb, esrb, done;
    int k, c, ns;
    logic nreq, nwc, nmw;
    logic [7:0] nstat;
    #3;
    em = '0; erb = 0;
    if (!rst) begin
      if (m_state == 0 && !bus.stall) begin
        k = 0; done = 0;
        while (!done && k < W) begin
          c = klass(bus.head_instr[k]);
          if (!bus.head_ready[k]) done = 1;
          else if (c == K_SW) begin
            if (k == 0 && bus.memio_bit) em[0] = 1;
            done = 1;
          end else if (c == K_BRK) done = 1;
          else if (c == K_BR) begin
            if (k + 1 >= W) done = 1;
            else if (!bus.head_ready[k+1]) done = 1;
            else begin
              em[k] = 1; em[k+1] = 1;
              if (bus.pred_addr[k] != bus.head_value[k]) begin erb = 1; done = 1; end
              k += 2;
            end
          end else begin
            em[k] = 1; k++;
          end
        end
      end else if (m_state == 1 && bus.mem_grant) em[0] = 1;
      else if (m_state == 2 && bus.rls && !bus.stall) em[0] = 1;
    end
    for (int j = 0; j < W; j++) begin
      ewe[j]  = em[j] && (klass(bus.head_instr[j]) == K_ALU);
      eclr[j] = em[j] && (bus.regstat_tag[j] == bus.head_tag[j]);
    end
    esrb = !rst && m_state == 0 && bus.stall && bus.head_ready[0] &&
           klass(bus.head_instr[0]) == K_BR && (bus.pred_addr[0] != bus.head_value[0]);
    chk("commit_mask", 32'(bus.commit_mask), 32'(em));
    chk("commit_cnt", 32'(bus.commit_cnt), $countones(em));
    chk("regfile_we", 32'(bus.regfile_we), 32'(ewe));
    chk("regstat_clr", 32'(bus.regstat_clr), 32'(eclr));
    chk("rollback", 32'(bus.rollback), 32'(erb));
    chk("stall_rollback", 32'(bus.stall_rollback), 32'(esrb));

    ns = m_state; nreq = m_mem_req; nwc = 0; nmw = 0; nstat = m_stat;
    if (rst) begin
      ns = 0; nreq = 0; nstat = 8'h00;
    end else if (m_state == 0) begin
      if (!bus.stall && bus.head_ready[0]) begin
        c = klass(bus.head_instr[0]);
        if (c == K_SW && bus.memio_bit) nmw = 1;
        else if (c == K_SW) begin ns = 1; nreq = 1; end
        else if (c == K_BRK) begin ns = 2; nstat = bus.head_instr[0][13:6]; end
      end
    end else if (m_state == 1) begin
      if (bus.mem_grant) begin ns = 0; nreq = 0; nwc = 1; end
    end else if (bus.rls && !bus.stall) begin
      ns = 0; nstat = 8'h00;
    end
    if (rst) begin m_ret = 0; m_rbc = 0; end
    else begin m_ret = m_ret + 32'($countones(em)); m_rbc = m_rbc + 16'(erb); end

    @(posedge clk); #1;
    m_state = ns; m_mem_req = nreq; m_wc = nwc; m_mw = nmw; m_stat = nstat;
    chk("mem_req", 32'(bus.mem_req), 32'(m_mem_req));
    chk("write_cache", 32'(bus.write_cache), 32'(m_wc));
    chk("memio_we", 32'(bus.memio_we), 32'(m_mw));
    chk("stat_output", 32'(bus.stat_output), 32'(m_stat));
`ifdef COMMIT_PERF_CTR_EN
    chk("retired_ctr", retired_ctr, m_ret);
    chk("rollback_ctr", 32'(rollback_ctr), 32'(m_rbc));
`endif
  endtask

  localparam logic [31:0] I_ADDU = 32'h0043_0821;  // addu r1,r2,r3
  localparam logic [31:0] I_ORI  = 32'h3442_00FF;  // ori r2,r2,0xff
  localparam logic [31:0] I_SW   = 32'hAC41_0010;  // sw r1,16(r2)
  localparam logic [31:0] I_BEQ  = 32'h1022_0004;  // beq r1,r2,+4
  localparam logic [31:0] I_BRK  = 32'h0000_168D;  // break code 0x5A

  initial begin
    // reset with ready entries present: nothing may retire
    idle_inputs();
    rst = 1;
    bus.head_ready = 2'b11; bus.head_instr[0] = I_ADDU; bus.head_instr[1] = I_ORI;
    #1 chk("rst_mask", 32'(bus.commit_mask), 0);
    run_cycle();
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_stat", 32'(bus.stat_output), 0);
    run_cycle();
    rst = 0;

    // dual ALU commit
    #1 chk("dual_mask", 32'(bus.commit_mask), 32'h3);
    chk("dual_cnt", 32'(bus.commit_cnt), 2);
    chk("dual_we", 32'(bus.regfile_we), 32'h3);
    run_cycle();

    // memory store, grant on the third request cycle
    idle_inputs();
    bus.head_ready = 2'b01; bus.head_instr[0] = I_SW;
    run_cycle();
    for (int n = 0; n < 3; n++) begin
      bus.mem_grant = (n == 2);
      #1 chk("st_req_held", 32'(bus.mem_req), 1);
      chk("st_mask", 32'(bus.commit_mask), (n == 2) ? 32'h1 : 32'h0);
      run_cycle();
    end
    chk("st_wc_pulse", 32'(bus.write_cache), 1);
    chk("st_req_drop", 32'(bus.mem_req), 0);

    // mispredicted branch with delay slot, then same window under stall
    idle_inputs();
    bus.head_ready = 2'b11; bus.head_instr[0] = I_BEQ; bus.head_instr[1] = I_ADDU;
    bus.head_value[0] = 32'h40; bus.pred_addr[0] = 32'h44;
    #1 chk("br_mask", 32'(bus.commit_mask), 32'h3);
    chk("br_rollback", 32'(bus.rollback), 1);
    run_cycle();
    bus.stall = 1;
    #1 chk("br_stall_rb", 32'(bus.stall_rollback), 1);
    chk("br_stall_mask", 32'(bus.commit_mask), 0);
    run_cycle();

    // break code 0x5A held until release
    idle_inputs();
    bus.head_ready = 2'b01; bus.head_instr[0] = I_BRK;
    run_cycle();
    chk("brk_code", 32'(bus.stat_output), 32'h5A);
    for (int n = 0; n < 10; n++) run_cycle();
    chk("brk_held", 32'(bus.stat_output), 32'h5A);
    bus.rls = 1;
    #1 chk("brk_rls_mask", 32'(bus.commit_mask), 32'h1);
    run_cycle();
    chk("brk_clear", 32'(bus.stat_output), 0);

    // reset in the second STORE cycle
    idle_inputs();
    bus.head_ready = 2'b01; bus.head_instr[0] = I_SW;
    run_cycle();
    run_cycle();
    rst = 1;
    #1 chk("st_rst_mask", 32'(bus.commit_mask), 0);
    run_cycle();
    chk("st_rst_req", 32'(bus.mem_req), 0);
    rst = 0;

`ifdef COMMIT_PERF_CTR_EN
    idle_inputs();
    rst = 1; run_cycle(); rst = 0;
    for (int n = 0; n < 5; n++) begin
      bus.head_ready = 2'b11;
      bus.head_instr[0] = (n == 4) ? I_BEQ : I_ADDU; bus.head_instr[1] = I_ORI;
      bus.head_value[0] = 32'h40; bus.pred_addr[0] = 32'h44;
      run_cycle();
    end
    chk("ctr_retired", retired_ctr, 10);
    chk("ctr_rollback", 32'(rollback_ctr), 1);
`endif

    // randomized windows
    for (int n = 0; n < 3000; n++) begin
      rnd_inputs();
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
